mphy_gen: RTL

//  Parametrised SPI pad-side PHY between the SPI controller (c_*) and the IO pads (p_*).

---
 rtl/mphy_gen.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mphy_gen.sv
// SPI pad-side PHY: parametrised lane count, run-time SDR/DDR, programmable
// input-capture delay with matched read-valid pipe, and enforced CS deselect gap.
module mphy_gen #(
  parameter  int LANES   = 4,
  parameter  int MAXDLY  = 3,
  parameter  int NCS_MIN = 2,
  localparam int DW      = $clog2(MAXDLY + 1),
  localparam int WW      = 2 * LANES
) (
  input  logic             c_ck,
  input  logic             c_rst,
  input  logic             c_en,
  input  logic             c_ddr,
  input  logic [DW-1:0]    c_dly,
  input  logic             c_ncs,
  input  logic [LANES-1:0] c_se,
  input  logic [WW-1:0]    c_so,
  input  logic             c_rd,
  output logic [WW-1:0]    c_si,
  output logic             c_si_vld,
  output logic             c_busy,
  output logic             p_ck,
  output logic             p_ncs,
  output logic [LANES-1:0] p_se,
  output logic [LANES-1:0] p_so,
  input  logic [LANES-1:0] p_si
);

  localparam int CW = (NCS_MIN > 2) ? $clog2(NCS_MIN) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [DW-1:0]      dly_q, dly_d;
  logic [LANES-1:0]   se_q, se_d;
  logic [LANES-1:0]   so0_q, so0_d, so1_q, so1_d, so2_q, so2_d;
  logic [LANES-1:0]   si0_q, si0_d, si1_q, si1_d, si2_q, si2_d;
  logic               rd0_q, rd0_d;
  logic [WW-1:0]      dpipe_q [MAXDLY];
  logic [WW-1:0]      dpipe_d [MAXDLY];
  logic [MAXDLY-1:0]  rpipe_q, rpipe_d;
  logic [WW-1:0]      raw, tap_data;
  logic               tap_rd;
  logic [WW-1:0]      si_q, si_d;
  logic               vld_q, vld_d;

  // Next-state logic; the c_en qualification lives in the state register.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!c_ncs) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (c_ncs) begin
          if (NCS_MIN == 1) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            cnt_d   = CW'(NCS_MIN - 2);
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p_ncs  = (state_q != ACTIVE);
    c_busy = (state_q == HOLD);
  end

  always_comb begin
    mode_d = mode_q;
    dly_d  = dly_q;
    if (state_q == IDLE) begin
      mode_d = c_ddr;
      dly_d  = (c_dly > DW'(MAXDLY)) ? DW'(MAXDLY) : c_dly;
    end
    se_d  = (state_d == ACTIVE) ? c_se : '0;

    so0_d = c_so[LANES-1:0];
    so1_d = c_so[WW-1:LANES];
    so2_d = so1_q;

    si0_d = p_si;
    si1_d = p_si;
    si2_d = si1_q;
    // Reads issued while deselected travel the pipe as a zero valid.
    rd0_d = c_rd & ~p_ncs;

    raw        = mode_q ? {si2_q, si0_q} : {{LANES{1'b0}}, si0_q};
    dpipe_d[0] = raw;
    rpipe_d[0] = rd0_q;
    for (int k = 1; k < MAXDLY; k++) begin
      dpipe_d[k] = dpipe_q[k-1];
      rpipe_d[k] = rpipe_q[k-1];
    end

    tap_data = raw;
    tap_rd   = rd0_q;
    for (int k = 0; k < MAXDLY; k++) begin
      if (dly_q == DW'(k + 1)) begin
        tap_data = dpipe_q[k];
        tap_rd   = rpipe_q[k];
      end
    end
    si_d  = tap_data;
    vld_d = tap_rd;
  end

  always_ff @(posedge c_ck or posedge c_rst) begin
    if (c_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      dly_q   <= '0;
      se_q    <= '0;
      so0_q   <= '0;
      so1_q   <= '0;
      si0_q   <= '0;
      si2_q   <= '0;
      rd0_q   <= 1'b0;
      // NOTE: the delay pipe is reset, not left as plain storage, so that
      // reads in flight are dropped by reset instead of surfacing later.
      for (int k = 0; k < MAXDLY; k++) dpipe_q[k] <= '0;
      rpipe_q <= '0;
      si_q    <= '0;
      vld_q   <= 1'b0;
    end else if (c_en) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dly_q   <= dly_d;
      se_q    <= se_d;
      so0_q   <= so0_d;
      so1_q   <= so1_d;
      si0_q   <= si0_d;
      si2_q   <= si2_d;
      rd0_q   <= rd0_d;
      for (int k = 0; k < MAXDLY; k++) dpipe_q[k] <= dpipe_d[k];
      rpipe_q <= rpipe_d;
      si_q    <= si_d;
      vld_q   <= vld_d;
    end
  end

  // Falling-edge half of the DDR tx and rx paths.
  always_ff @(negedge c_ck or posedge c_rst) begin
    if (c_rst) begin
      so2_q <= '0;
      si1_q <= '0;
    end else if (c_en) begin
      so2_q <= so2_d;
      si1_q <= si1_d;
    end
  end

  assign p_ck     = c_ck;
  assign p_se     = se_q;
  assign p_so     = (mode_q && !c_ck) ? so2_q : so0_q;
  assign c_si     = si_q;
  assign c_si_vld = vld_q;

endmodule
